ram_param: RTL and testbench
============================

// Module: ram_param
// PURPOSE
//   Parametrised single-port synchronous RAM; successor to the fixed 8x16 RAM.
//   Adds a registered read with valid strobe and a hardware clear sequencer
//   that zeroes every word after reset or on request.
//   Used as generic register-file/data memory in the datapath.
// PARAMETERS
//   LARGURA  16  data word width in bits (>=1)
//   PROF     8   number of words (>=2; need not be a power of two)
//   END_W    $clog2(PROF)  address width (localparam, not overridable)
// PORTS
//   clk            in   1        clock, all state updates on rising edge
//   reset          in   1        asynchronous, active-high reset
//   endereco       in   END_W    word address for read or write
//   dados_entrada  in   LARGURA  write data
//   enable         in   1        write enable, sampled at rising clk
//   ler            in   1        read request, sampled at rising clk
//   limpar         in   1        start clear of whole memory (one-cycle pulse)
//   dados_saida    out  LARGURA  registered read data
//   valido         out  1        high exactly 1 cycle when dados_saida updated
//   ocupado        out  1        high while clear sequencer runs
// BEHAVIOUR
//   - Reset (async): dados_saida=0, valido=0, ocupado=1, state=LIMPANDO, cnt=0.
//   - FSM states: LIMPANDO, OCIOSO.
//     LIMPANDO: each cycle mem[cnt]<=0, cnt++; at cnt==PROF-1 -> OCIOSO,
//       ocupado falls the cycle after the last word is cleared (PROF cycles).
//       enable/ler/limpar ignored; valido stays 0; dados_saida holds.
//     OCIOSO: ocupado=0; limpar=1 -> LIMPANDO with cnt=0 (next edge).
//   - Priority in OCIOSO: limpar > (enable, ler). limpar with enable/ler in the
//     same cycle: write and read are dropped.
//   - Write: enable=1 -> mem[endereco]<=dados_entrada at that edge.
//   - Read: ler=1 -> dados_saida<=mem[endereco] at that edge, valido=1 for
//     that following cycle only. Latency 1 cycle. ler=0: dados_saida holds,
//     valido=0. Back-to-back reads allowed every cycle.
//   - Same-cycle write+read, same address: read-first (old word returned).
//   - Out-of-range address (endereco>=PROF, non-power-of-two PROF): write
//     ignored; read returns 0 with valido=1.
//   - Reset mid-clear or mid-operation: clear restarts from word 0; memory
//     contents beyond cleared words are don't-care until clear completes.
//   - No combinational path from inputs to outputs.
// CONFIGURATION
//   RAM_WRITE_FIRST_EN defined: same-cycle write+read to same address returns
//     dados_entrada (write-first bypass). Different addresses unaffected.
//   Not defined: read-first, as above.
// TESTING
//   1. PROF=8: release reset -> ocupado=1 for 8 cycles then 0; read addr 0..7
//      -> dados_saida=16'h0000, valido=1 each read cycle.
//   2. Write 16'hAAAA @0, 16'h8000 @1; ler @0 -> next cycle dados_saida=16'hAAAA,
//      valido=1 one cycle; ler @1 -> 16'h8000.
//   3. Addr 1 holds 16'h8000; enable=1 dados_entrada=16'h1234 ler=1 @1 ->
//      dados_saida=16'h8000 (macro off) / 16'h1234 (RAM_WRITE_FIRST_EN); then
//      ler @1 -> 16'h1234 both builds.
//   4. After writes, pulse limpar -> ocupado 8 cycles; writes/reads issued
//      meanwhile ignored (valido=0); afterwards all addresses read 16'h0000.
//   5. Assert reset during clear cycle 3 -> dados_saida=0, valido=0 immediately;
//      after release ocupado=1 for a full 8 cycles.
//   6. PROF=6: write 16'hFFFF @7 -> ignored; ler @7 -> 16'h0000 valido=1;
//      addr 0..5 unaffected.

Source files
------------

// File: rtl/ram_param.sv
// ram_param: parametrised single-port RAM with registered read, valid strobe and clear sequencer.
// Define RAM_WRITE_FIRST_EN for write-first bypass on same-address write+read.
module ram_param #(
    parameter int LARGURA = 16,
    parameter int PROF = 8,
    localparam int END_W = $clog2(PROF)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [END_W-1:0]   endereco,
    input  logic [LARGURA-1:0] dados_entrada,
    input  logic               enable,
    input  logic               ler,
    input  logic               limpar,
    output logic [LARGURA-1:0] dados_saida,
    output logic               valido,
    output logic               ocupado
);
    localparam logic [0:0] LIMPANDO = 1'b0;
    localparam logic [0:0] OCIOSO = 1'b1;
    localparam logic [END_W:0] LIMITE = (END_W+1)'(PROF);
    localparam logic [END_W-1:0] ULTIMO = END_W'(PROF-1);
    logic [LARGURA-1:0] mem [PROF];
    logic [0:0] estado;
    logic [END_W-1:0] cnt;
    logic no_intervalo, escrever, leitura;
    logic [LARGURA-1:0] lido;
    always_comb begin
        no_intervalo = {1'b0, endereco} < LIMITE;
        escrever = estado == OCIOSO && !limpar && enable && no_intervalo;
        leitura = estado == OCIOSO && !limpar && ler;
`ifdef RAM_WRITE_FIRST_EN
        lido = !no_intervalo ? '0 : escrever ? dados_entrada : mem[endereco];
`else
        lido = no_intervalo ? mem[endereco] : '0;
`endif
    end
    assign ocupado = estado == LIMPANDO;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= LIMPANDO;
            cnt <= '0;
            dados_saida <= '0;
            valido <= 1'b0;
        end else if (estado == LIMPANDO) begin
            valido <= 1'b0;
            cnt <= cnt == ULTIMO ? '0 : cnt + 1'b1;
            if (cnt == ULTIMO) estado <= OCIOSO;
        end else begin
            valido <= leitura;
            if (leitura) dados_saida <= lido;
            if (limpar) begin
                estado <= LIMPANDO;
                cnt <= '0;
            end
        end
    end
    // Storage has no reset; the clear sequencer zeroes it word by word.
    always_ff @(posedge clk) begin
        if (estado == LIMPANDO) mem[cnt] <= '0;
        else if (escrever) mem[endereco] <= dados_entrada;
    end
endmodule

// File: tb/tb_ram_param.sv
// tb_ram_param: scoreboard bench for ram_param with PROF=8 and PROF=6 instances.
module tb_ram_param;
    logic clk = 0;
    always #5 clk = ~clk;
    logic rst8, en8, ler8, lim8, v8, oc8;
    logic [2:0] a8;
    logic [15:0] d8, do8;
    logic rst6, en6, ler6, lim6, v6, oc6;
    logic [2:0] a6;
    logic [15:0] d6, do6;
    logic [15:0] q8[$], q6[$];
    int checks = 0, failures = 0;
    int n8, n6;

    ram_param #(.LARGURA(16), .PROF(8)) dut8 (
        .clk(clk), .reset(rst8), .endereco(a8), .dados_entrada(d8), .enable(en8),
        .ler(ler8), .limpar(lim8), .dados_saida(do8), .valido(v8), .ocupado(oc8));
    ram_param #(.LARGURA(16), .PROF(6)) dut6 (
        .clk(clk), .reset(rst6), .endereco(a6), .dados_entrada(d6), .enable(en6),
        .ler(ler6), .limpar(lim6), .dados_saida(do6), .valido(v6), .ocupado(oc6));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (v8) begin
            if (q8.size() == 0) chk("v8_spurious", 1, 0);
            else chk("rd8", {16'h0, do8}, {16'h0, q8.pop_front()});
        end
        if (v6) begin
            if (q6.size() == 0) chk("v6_spurious", 1, 0);
            else chk("rd6", {16'h0, do6}, {16'h0, q6.pop_front()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit s, input logic [2:0] a, input logic [15:0] d);
        if (s) begin en6 = 1; a6 = a; d6 = d; end
        else begin en8 = 1; a8 = a; d8 = d; end
        step();
        en6 = 0;
        en8 = 0;
    endtask

    task automatic rd(input bit s, input logic [2:0] a, input logic [15:0] e);
        if (s) begin ler6 = 1; a6 = a; q6.push_back(e); end
        else begin ler8 = 1; a8 = a; q8.push_back(e); end
        step();
        ler6 = 0;
        ler8 = 0;
    endtask

    task automatic measure(input bit s, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!(s ? oc6 : oc8)) break;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        rst8 = 1; rst6 = 1;
        {en8, ler8, lim8, en6, ler6, lim6} = '0;
        a8 = 0; d8 = 0; a6 = 0; d6 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout8", {16'h0, do8}, 0);
        chk("rst_v8", {31'h0, v8}, 0);
        chk("rst_oc8", {31'h0, oc8}, 1);
        chk("rst_oc6", {31'h0, oc6}, 1);
        rst8 = 0; rst6 = 0;
        fork
            measure(0, n8);
            measure(1, n6);
        join
        chk("busy8_after_reset", n8, 8);
        chk("busy6_after_reset", n6, 6);
        for (int i = 0; i < 8; i++) rd(0, 3'(i), 16'h0000);
        wr(0, 0, 16'hAAAA);
        wr(0, 1, 16'h8000);
        rd(0, 0, 16'hAAAA);
        rd(0, 1, 16'h8000);
        en8 = 1; ler8 = 1; a8 = 1; d8 = 16'h1234;
`ifdef RAM_WRITE_FIRST_EN
        q8.push_back(16'h1234);
`else
        q8.push_back(16'h8000);
`endif
        step();
        en8 = 0; ler8 = 0;
        rd(0, 1, 16'h1234);
        en8 = 1; d8 = 16'h5555; a8 = 5;
        step();
        en8 = 0;
        ler8 = 1; a8 = 0; q8.push_back(16'hAAAA);
        step();
        ler8 = 0;
        rd(0, 5, 16'h5555);
        lim8 = 1; en8 = 1; ler8 = 1; a8 = 2; d8 = 16'hBEEF;
        step();
        lim8 = 0;
        measure(0, n8);
        chk("busy8_clear", n8, 8);
        en8 = 0; ler8 = 0;
        for (int i = 0; i < 8; i++) rd(0, 3'(i), 16'h0000);
        wr(0, 3, 16'hCAFE);
        rd(0, 3, 16'hCAFE);
        lim8 = 1;
        step();
        lim8 = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("preclear_dout_held", {16'h0, do8}, {16'h0, 16'hCAFE});
        rst8 = 1;
        #1;
        chk("midclear_rst_dout", {16'h0, do8}, 0);
        chk("midclear_rst_v", {31'h0, v8}, 0);
        chk("midclear_rst_oc", {31'h0, oc8}, 1);
        @(posedge clk);
        #1;
        rst8 = 0;
        measure(0, n8);
        chk("busy8_after_midreset", n8, 8);
        rd(0, 3, 16'h0000);
        for (int i = 0; i < 6; i++) wr(1, 3'(i), 16'h1000 + 16'(i));
        wr(1, 7, 16'hFFFF);
        wr(1, 6, 16'hEEEE);
        rd(1, 7, 16'h0000);
        rd(1, 6, 16'h0000);
        for (int i = 0; i < 6; i++) rd(1, 3'(i), 16'h1000 + 16'(i));
        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q6_drained", q6.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
